// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: data width, NOP encoding, fetch FSM
// states and the IF/ID pipeline bundle.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: rst > flush > load > hold.
// A flush drops the slot to a bubble (valid=0, NOP) but keeps the PC fields.
module if_id_reg
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_WORD = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t data_i,
  output if_id_t q_o
);

  if_id_t slot_q;
  if_id_t slot_d;

  // Select next slot contents from flush/load/hold controls.
  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d.valid = 1'b0;
      slot_d.instr = NOP_WORD;
    end else if (load_i) begin
      slot_d = data_i;
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot register with synchronous reset to an empty bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q.valid    <= 1'b0;
      slot_q.pc       <= 32'h0000_0000;
      slot_q.pc_plus4 <= 32'h0000_0004;
      slot_q.instr    <= NOP_WORD;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the instruction memory
// address and captures the returned word into the IF/ID register.
// Per-edge priority: rst > redirect > stall > halt > advance.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// is loaded unmasked, the stage halts and fetch_misalign latches until rst.
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic [31:0] fetch_count,
  output logic        halted
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_plus4_s;
  logic         load_s;
  logic         flush_s;
  logic         trap_lock_s;
  if_id_t       cap_s;
  if_id_t       slot_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign trap_lock_s = misalign_q;
`else
  assign trap_lock_s = 1'b0;
`endif

  assign pc_plus4_s = pc_q + 32'd4;

  // Next PC, FSM state, delivered-count and IF/ID controls.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    count_d = count_q;
    load_s  = 1'b0;
    flush_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    if (redirect_valid) begin
      flush_s = 1'b1;
      pc_d    = redirect_target & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        pc_d       = redirect_target;
        state_d    = S_HALT;
        misalign_d = 1'b1;
      end else begin
        misalign_d = misalign_q;
      end
`endif
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      case (state_q)
        S_RUN: begin
          load_s  = 1'b1;
          pc_d    = pc_plus4_s;
          count_d = count_q + 32'd1;
          if (halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_RUN;
          end
        end
        S_HALT: begin
          flush_s = 1'b1;
          if (!halt && !trap_lock_s) begin
            state_d = S_RUN;
          end else begin
            state_d = S_HALT;
          end
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  // PC, FSM state and fetch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= 32'h0000_0000;
      state_q <= S_RUN;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign fetch_misalign = misalign_q;
`endif

  assign cap_s.valid    = 1'b1;
  assign cap_s.pc       = pc_q;
  assign cap_s.pc_plus4 = pc_plus4_s;
  assign cap_s.instr    = imem_data;

  if_id_reg #(.NOP_WORD(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_s),
    .flush_i (flush_s),
    .data_i  (cap_s),
    .q_o     (slot_s)
  );

  assign imem_addr   = pc_q;
  assign id_valid    = slot_s.valid;
  assign id_pc       = slot_s.pc;
  assign id_pc_plus4 = slot_s.pc_plus4;
  assign id_instr    = slot_s.instr;
  assign fetch_count = count_q;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational memory.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic [31:0] fetch_count;
  logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int n_checks;
  int n_errors;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_instr        (id_instr),
    .fetch_count     (fetch_count),
    .halted          (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: two addi words at 0 and 4, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0012_8293;
      32'h0000_0004: mem_word = 32'h0022_8313;
      default:       mem_word = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the full IF/ID slot plus fetch address and counter.
  task automatic check_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] cnt,
                            input logic [31:0] addr);
    check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
    check({tag, ".pc"}, id_pc, pc);
    check({tag, ".instr"}, id_instr, ins);
    check({tag, ".count"}, fetch_count, cnt);
    check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; halt = 1'b0;
    step(); step();
    check_slot("reset", 1'b0, 32'h0, 32'h13, 32'd0, 32'h0);
    check("reset.plus4", id_pc_plus4, 32'h4);
    check("reset.halted", {31'd0, halted}, 32'd0);

    // 1: first two fetches
    rst = 1'b0;
    step();
    check_slot("t1e1", 1'b1, 32'h0, 32'h0012_8293, 32'd1, 32'h4);
    step();
    check_slot("t1e2", 1'b1, 32'h4, 32'h0022_8313, 32'd2, 32'h8);
    check("t1e2.plus4", id_pc_plus4, 32'h8);

    // 2: stall holds everything for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_slot("t2stall", 1'b1, 32'h4, 32'h0022_8313, 32'd2, 32'h8);
    end
    stall = 1'b0;
    step();
    check_slot("t2resume", 1'b1, 32'h8, mem_word(32'h8), 32'd3, 32'hC);

    // 3: redirect wins over stall, one bubble
    redirect_valid = 1'b1; redirect_target = 32'h10; stall = 1'b1;
    step();
    check_slot("t3flush", 1'b0, 32'h8, 32'h13, 32'd3, 32'h10);
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    check_slot("t3tgt", 1'b1, 32'h10, mem_word(32'h10), 32'd4, 32'h14);
    check("t3tgt.plus4", id_pc_plus4, 32'h14);

    // 4: halt pulse with pc=0xC
    redirect_valid = 1'b1; redirect_target = 32'hC;
    step();
    redirect_valid = 1'b0; halt = 1'b1;
    step();
    check_slot("t4cap", 1'b1, 32'hC, mem_word(32'hC), 32'd5, 32'h10);
    check("t4cap.halted", {31'd0, halted}, 32'd1);
    halt = 1'b0;
    step();
    check_slot("t4idle", 1'b0, 32'hC, 32'h13, 32'd5, 32'h10);
    check("t4idle.halted", {31'd0, halted}, 32'd0);
    step();
    check_slot("t4run", 1'b1, 32'h10, mem_word(32'h10), 32'd6, 32'h14);

    // 5: PC wrap-around
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check_slot("t5top", 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'd7, 32'h0);
    check("t5top.plus4", id_pc_plus4, 32'h0);
    step();
    check_slot("t5wrap", 1'b1, 32'h0, 32'h0012_8293, 32'd8, 32'h4);
    check("t5wrap.plus4", id_pc_plus4, 32'h4);

`ifdef FETCH_MISALIGN_TRAP_EN
    // 6: misaligned redirect traps until reset
    check("t6pre.mis", {31'd0, fetch_misalign}, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'h6;
    step();
    redirect_valid = 1'b0;
    check("t6.mis", {31'd0, fetch_misalign}, 32'd1);
    check("t6.halted", {31'd0, halted}, 32'd1);
    check("t6.addr", imem_addr, 32'h6);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6hold.valid", {31'd0, id_valid}, 32'd0);
      check("t6hold.halted", {31'd0, halted}, 32'd1);
      check("t6hold.addr", imem_addr, 32'h6);
    end
`else
    // Misaligned targets are masked to word alignment
    redirect_valid = 1'b1; redirect_target = 32'h23;
    step();
    redirect_valid = 1'b0;
    check("mask.addr", imem_addr, 32'h20);
    check("mask.halted", {31'd0, halted}, 32'd0);
    step();
    check_slot("mask.cap", 1'b1, 32'h20, mem_word(32'h20), 32'd9, 32'h24);
`endif

    // Reset overrides stall, redirect and halt
    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1;
    redirect_target = 32'h40; halt = 1'b1;
    step();
    check_slot("rst2", 1'b0, 32'h0, 32'h13, 32'd0, 32'h0);
    check("rst2.plus4", id_pc_plus4, 32'h4);
    check("rst2.halted", {31'd0, halted}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst2.mis", {31'd0, fetch_misalign}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
